// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Also provides the helper that sizes the baud counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } uart_state_e;

    localparam int DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int DEF_BAUD_RATE   = 115_200;
    localparam int DATA_BITS       = 8;

    // Width needed to hold the values 0..clks_per_bit-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: emits a one-cycle tick on the last cycle of every bit period.
// Cleared at frame start so the first bit period is exactly CLKS_PER_BIT cycles long.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, idle-high line, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TX_start,
    input  logic [7:0] TX_data,
    output logic       TX,
    output logic       q_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 baud_clear;
    logic                 baud_tick;
    logic [2:0]           bit_nxt;

    assign bit_nxt = bit_idx_q + 3'd1;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(reset),
        .clear(baud_clear),
        .en   (state_q != IDLE),
        .tick (baud_tick)
    );

    // Line and busy are computed one state ahead so both come straight from flops.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        baud_clear = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (TX_start) begin
                    shift_d    = TX_data;
                    baud_clear = 1'b1;
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_nxt;
                        tx_d      = shift_q[bit_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX     = tx_q;
    assign q_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a mid-bit
// sampling receiver and a busy-length monitor pop and compare independently.
module tb_uart_tx;

    localparam int N = 434;

`ifdef UART_TX_PARITY_EN
    localparam int NB       = 11;
    localparam int BUSY_CYC = 4774;
    // Transmission order, bit 0 first: start, d0..d7, parity, stop.
    localparam logic [10:0] E_A5 = 11'h54A;
    localparam logic [10:0] E_3C = 11'h478;
    localparam logic [10:0] E_81 = 11'h502;
    localparam logic [10:0] E_42 = 11'h484;
    localparam logic [10:0] E_55 = 11'h4AA;
    localparam logic [10:0] E_07 = 11'h60E;
`else
    localparam int NB       = 10;
    localparam int BUSY_CYC = 4340;
    // Transmission order, bit 0 first: start, d0..d7, stop.
    localparam logic [10:0] E_A5 = 11'h34A;
    localparam logic [10:0] E_3C = 11'h278;
    localparam logic [10:0] E_81 = 11'h302;
    localparam logic [10:0] E_42 = 11'h284;
    localparam logic [10:0] E_55 = 11'h2AA;
    localparam logic [10:0] E_07 = 11'h20E;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       TX_start;
    logic [7:0] TX_data;
    logic       TX;
    logic       q_busy;

    int compared   = 0;
    int mismatched = 0;
    logic [10:0] sb_q[$];

    uart_tx dut (
        .clk     (clk),
        .reset   (reset),
        .TX_start(TX_start),
        .TX_data (TX_data),
        .TX      (TX),
        .q_busy  (q_busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] exp, input bit push);
        @(negedge clk);
        TX_data  = d;
        TX_start = 1'b1;
        if (push) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        check("accept_tx_low", int'(TX), 0);
        check("accept_busy", int'(q_busy), 1);
        @(negedge clk);
        TX_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!q_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check(name, 1, 0);
    endtask

    // Mid-bit sampling receiver.
    initial begin : frame_mon
        logic        prev;
        logic [10:0] got;
        logic [10:0] exp;
        bit          ab;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b1;
            end else if (prev && !TX) begin
                got = '0;
                ab  = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    for (int c = 0; c < ((k == 0) ? N / 2 : N); c++) begin
                        @(negedge clk);
                        if (!reset) begin
                            ab = 1'b1;
                            break;
                        end
                    end
                    if (ab) break;
                    got[k] = TX;
                end
                if (!ab) begin
                    if (sb_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL spurious_frame: got %0h, expected no frame", got);
                    end else begin
                        exp = sb_q.pop_front();
                        check("frame_bits", int'(got), int'(exp));
                    end
                end
                prev = TX;
            end else begin
                prev = TX;
            end
        end
    end

    // Busy pulse length; frames cut by reset are not measured.
    initial begin : busy_mon
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
            end else if (q_busy) begin
                cnt++;
            end else if (cnt != 0) begin
                check("busy_cycles", cnt, BUSY_CYC);
                cnt = 0;
            end
        end
    end

    initial begin
        reset    = 1'b0;
        TX_start = 1'b0;
        TX_data  = 8'h00;
        #100;
        check("in_reset_tx", int'(TX), 1);
        check("in_reset_busy", int'(q_busy), 0);
        #100;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_tx", int'(TX), 1);
        check("post_reset_busy", int'(q_busy), 0);

        // 0xA5 with an ignored strobe of 0xFF in the middle of the frame.
        send(8'hA5, E_A5, 1'b1);
        repeat (3 * N) @(negedge clk);
        TX_data  = 8'hFF;
        TX_start = 1'b1;
        @(negedge clk);
        TX_start = 1'b0;
        wait_idle("timeout_a5");
        repeat (2 * N) @(negedge clk);
        check("no_second_frame_tx", int'(TX), 1);
        check("no_second_frame_busy", int'(q_busy), 0);

        send(8'h3C, E_3C, 1'b1);
        wait_idle("timeout_3c");
        repeat (10) @(negedge clk);

        // Back-to-back: strobe held through the end of the 0x81 frame.
        @(negedge clk);
        TX_data  = 8'h81;
        TX_start = 1'b1;
        sb_q.push_back(E_81);
        @(negedge clk);
        TX_data = 8'h42;
        sb_q.push_back(E_42);
        wait_idle("timeout_81");
        @(posedge clk);
        #1;
        check("b2b_busy", int'(q_busy), 1);
        check("b2b_tx_low", int'(TX), 0);
        @(negedge clk);
        TX_start = 1'b0;
        wait_idle("timeout_42");
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 3.
        send(8'hC3, 11'h000, 1'b0);
        repeat (N + 3 * N + N / 2) @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midreset_tx", int'(TX), 1);
        check("midreset_busy", int'(q_busy), 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("after_midreset_tx", int'(TX), 1);

        send(8'h55, E_55, 1'b1);
        wait_idle("timeout_55");
        repeat (10) @(negedge clk);

        send(8'h07, E_07, 1'b1);
        wait_idle("timeout_07");
        repeat (N) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
